// File: rtl/dsm_sample_sequencer.sv
// dsm_sample_sequencer
//
// Feeds DSM_top.vin at a controlled rate. Samples arrive over a valid/ready
// handshake into a small FIFO. Each popped sample is held on vin for exactly
// OSR clock cycles. The control FSM steps through IDLE -> PRIME -> RUN -> STOP:
//   PRIME waits until the FIFO is half full before the first pop.
//   RUN pops one sample per period.
//   STOP lets the current period finish, then zeroes vin and flushes the FIFO.
//
// Build option:
//   DSM_SEQ_HOLD_LAST_EN  defined   : on underflow, vin keeps the last sample.
//                         undefined : on underflow, vin is forced to zero.
//
// Ports:
//   clock          single rising-edge clock
//   reset          asynchronous, active-high; clears all state
//   enable         level: 1 = run the modulator feed, 0 = stop
//   s_data/s_valid input sample stream
//   s_ready        FIFO not full (decoded from the registered count only)
//   vin            registered sample to DSM_top.vin
//   sample_strobe  one-cycle pulse when vin first shows a newly popped sample
//   underflow      sticky; FIFO was empty at a sample boundary in RUN
//   busy           FSM is not in IDLE

module dsm_sample_sequencer #(
    parameter int WIDTH = 20,
    parameter int OSR   = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] vin,
    output logic             sample_strobe,
    output logic             underflow,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OSR);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_HALF = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] PER_LOAD = CW'(OSR - 1);
    localparam logic [CW-1:0] PER_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [CW-1:0]    period_cnt;

    logic push, pop, reload, zero_cnt, flush, set_uf, clr_uf, boundary;

    assign s_ready  = (count != CNT_FULL);
    assign push     = s_valid & s_ready;
    assign boundary = (period_cnt == '0);
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-edge control decode
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        reload    = 1'b0;
        zero_cnt  = 1'b0;
        flush     = 1'b0;
        set_uf    = 1'b0;
        clr_uf    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = PRIME;
                    clr_uf    = 1'b1;
                end
            end
            PRIME: begin
                if (!enable) begin
                    // Zeroing the counter makes STOP finish on the very next edge.
                    state_nxt = STOP;
                    zero_cnt  = 1'b1;
                end else if (count >= CNT_HALF) begin
                    state_nxt = RUN;
                    pop       = 1'b1;
                    reload    = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    reload = 1'b1;
                    if (count != '0) begin
                        pop = 1'b1;
                    end else begin
                        set_uf = 1'b1;
                    end
                end
                // The running period is never cut short; STOP waits it out.
                if (!enable) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (boundary) begin
                    flush     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Period counter: reloads on each boundary, counts down in RUN/STOP
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (reload) begin
            period_cnt <= PER_LOAD;
        end else if (zero_cnt) begin
            period_cnt <= '0;
        end else if ((state == RUN) || (state == STOP)) begin
            period_cnt <= period_cnt - PER_ONE;
        end
    end

    // FIFO control; a flush discards anything pushed on the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: data only, no reset needed
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Output stage: vin, strobe and sticky underflow
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vin           <= '0;
            sample_strobe <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            sample_strobe <= pop;
            if (pop) begin
                vin <= mem[rd_ptr];
            end else if (set_uf) begin
`ifdef DSM_SEQ_HOLD_LAST_EN
                vin <= vin;
`else
                vin <= '0;
`endif
            end else if (flush) begin
                vin <= '0;
            end
            if (clr_uf) begin
                underflow <= 1'b0;
            end else if (set_uf) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dsm_sample_sequencer.sv
// tb_dsm_sample_sequencer
//
// Bench for dsm_sample_sequencer with OSR=4, DEPTH=4.
// Every accepted sample is queued as an expected vin value. A negedge monitor
// pops the queue on each sample_strobe. It also checks the strobe spacing and
// that vin is held between strobes. Directed sequences cover reset, prime/run,
// backpressure, underflow, stop/flush and asynchronous reset mid-run.

module tb_dsm_sample_sequencer;

    localparam int WIDTH = 20;
    localparam int OSR   = 4;
    localparam int DEPTH = 4;

`ifdef DSM_SEQ_HOLD_LAST_EN
    localparam logic [31:0] UF_VIN = 32'h00002;
`else
    localparam logic [31:0] UF_VIN = 32'h00000;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] vin;
    logic             sample_strobe;
    logic             underflow;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] last_vin;
    bit               have_last = 1'b0;
    int               last_cyc  = 0;

    dsm_sample_sequencer #(
        .WIDTH (WIDTH),
        .OSR   (OSR),
        .DEPTH (DEPTH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .vin           (vin),
        .sample_strobe (sample_strobe),
        .underflow     (underflow),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset || !busy) begin
            have_last = 1'b0;
        end else if (sample_strobe) begin
            check("strobe_has_expect", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("vin_sample", 32'(vin), 32'(exp_q.pop_front()));
            end
            if (have_last) begin
                check("strobe_gap", 32'(cyc - last_cyc), 32'(OSR));
            end
            have_last = 1'b1;
            last_vin  = vin;
            last_cyc  = cyc;
        end else if (have_last && !underflow) begin
            check("vin_hold", 32'(vin), 32'(last_vin));
        end
    end

    // Offer one sample; called and returns on a negedge.
    task automatic send(input logic [WIDTH-1:0] d, input bit after_pop);
        bit done = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (s_ready) begin
                if (after_pop) begin
                    check("bp_accept_after_pop", 32'(sample_strobe), 32'd1);
                end
                exp_q.push_back(d);
                done = 1'b1;
            end
            @(negedge clock);
        end
        s_valid = 1'b0;
        if (!done) check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_strobe();
        bit seen = 1'b0;
        for (int i = 0; i < 4 * OSR + 8 && !seen; i++) begin
            @(negedge clock);
            seen = sample_strobe;
        end
        check("strobe_wait", 32'(seen), 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 4 * OSR + 8 && !idle; i++) begin
            @(negedge clock);
            idle = !busy;
        end
        check("idle_wait", 32'(idle), 32'd1);
    endtask

    initial begin
        int k;
        reset   = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;

        // Reset values
        @(negedge clock);
        check("rst_vin",     32'(vin), 32'd0);
        check("rst_strobe",  32'(sample_strobe), 32'd0);
        check("rst_uf",      32'(underflow), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        reset = 1'b0;
        @(negedge clock);

        // Prime and run: three samples, stop during the third period
        send(20'h00001, 1'b0);
        send(20'h00002, 1'b0);
        send(20'h00003, 1'b0);
        check("prime_idle_vin", 32'(vin), 32'd0);
        enable = 1'b1;
        wait_strobe();
        wait_strobe();
        wait_strobe();
        enable = 1'b0;
        wait_idle();
        check("run_end_vin", 32'(vin), 32'd0);
        check("run_end_uf",  32'(underflow), 32'd0);

        // Backpressure: fill in IDLE, fifth sample accepted right after first pop
        send(20'h00010, 1'b0);
        send(20'h00011, 1'b0);
        send(20'h00012, 1'b0);
        send(20'h00013, 1'b0);
        check("bp_full", 32'(s_ready), 32'd0);
        enable = 1'b1;
        send(20'h00014, 1'b1);
        wait_strobe();
        wait_strobe();
        wait_strobe();
        wait_strobe();
        enable = 1'b0;
        wait_idle();
        check("bp_uf", 32'(underflow), 32'd0);

        // Underflow: two samples, third boundary finds the FIFO empty
        send(20'h00001, 1'b0);
        send(20'h00002, 1'b0);
        enable = 1'b1;
        wait_strobe();
        wait_strobe();
        k = 0;
        while (!underflow && k < 4 * OSR) begin
            @(negedge clock);
            k++;
        end
        check("uf_delay",     32'(k), 32'(OSR));
        check("uf_flag",      32'(underflow), 32'd1);
        check("uf_no_strobe", 32'(sample_strobe), 32'd0);
        check("uf_vin",       32'(vin), UF_VIN);
        enable = 1'b0;
        wait_idle();
        check("uf_sticky", 32'(underflow), 32'd1);

        // Stop: drop enable in the first cycle of a period
        send(20'h0000A, 1'b0);
        send(20'h0000B, 1'b0);
        send(20'h0000C, 1'b0);
        enable = 1'b1;
        wait_strobe();
        check("stop_uf_clear", 32'(underflow), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < OSR - 1; i++) begin
            @(negedge clock);
            check("stop_vin_hold", 32'(vin), 32'h0000A);
            check("stop_busy",     32'(busy), 32'd1);
        end
        @(negedge clock);
        check("stop_vin_zero", 32'(vin), 32'd0);
        check("stop_idle",     32'(busy), 32'd0);
        check("stop_strobe",   32'(sample_strobe), 32'd0);
        exp_q.delete();
        // A flushed FIFO takes exactly DEPTH samples before s_ready drops
        send(20'h00005, 1'b0);
        send(20'h00006, 1'b0);
        send(20'h00007, 1'b0);
        check("flush_not_full", 32'(s_ready), 32'd1);
        send(20'h00008, 1'b0);
        check("flush_full", 32'(s_ready), 32'd0);

        // Asynchronous reset mid-run
        enable = 1'b1;
        wait_strobe();
        @(negedge clock);
        check("mid_vin", 32'(vin), 32'h00005);
        reset = 1'b1;
        #1;
        check("arst_vin",     32'(vin), 32'd0);
        check("arst_busy",    32'(busy), 32'd0);
        check("arst_s_ready", 32'(s_ready), 32'd1);
        check("arst_uf",      32'(underflow), 32'd0);
        check("arst_strobe",  32'(sample_strobe), 32'd0);
        exp_q.delete();
        enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
